// File: rtl/axis_frame_pkg.sv
// rtl/axis_frame_pkg.sv - shared frame-size helpers and packer state encoding
package axis_frame_pkg;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_HOLD = 2'd1,
    ST_SKIP = 2'd2
  } frame_state_t;

  function automatic int n_pix(input int r, input int c);
    return r * c;
  endfunction

  // A one-pixel frame still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_frame_hold_reg.sv
// rtl/axis_frame_hold_reg.sv - frame-wide output holding register with valid/ready
module axis_frame_hold_reg
  import axis_frame_pkg::*;
#(
  parameter int DW = 200
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          m_ready,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          can_load
);

  // A load is legal when the register is empty or is handing off on this edge.
  assign can_load = !m_valid || m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= load_data;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_pixel_to_frame.sv
// rtl/axis_pixel_to_frame.sv - packs a pixel-serial stream into one frame-wide beat
// Optional last-pixel framing check: AXIS_PIXEL_TO_FRAME_LAST_CHECK_EN
module axis_pixel_to_frame
  import axis_frame_pkg::*;
#(
  parameter int R_I = 5,
  parameter int C_I = 5,
  parameter int W_I = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     s_axis_pixel_ready,
  input  logic                     s_axis_pixel_valid,
  input  logic [W_I-1:0]           s_axis_pixel_data,
  input  logic                     s_axis_pixel_last,
  input  logic                     m_axis_frame_ready,
  output logic                     m_axis_frame_valid,
  output logic [R_I*C_I*W_I-1:0]   m_axis_frame_data,
  output logic                     frame_err_short,
  output logic                     frame_err_long
);

  localparam int N  = n_pix(R_I, C_I);
  localparam int KW = cnt_width(N);
  localparam int FW = N * W_I;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  frame_state_t   state;
  logic [KW-1:0]  k;
  logic [FW-1:0]  fill;
  logic           accept;
  logic           at_last;
  logic           can_load;
  logic           hold_drain;
  logic           load;
  logic [FW-1:0]  load_data;

  // Ready depends only on state and reset, never on valid or downstream ready.
  assign s_axis_pixel_ready = !rst && (state != ST_HOLD);
  assign accept  = s_axis_pixel_valid && s_axis_pixel_ready;
  assign at_last = (k == K_LAST);

  assign hold_drain = (state == ST_HOLD) && m_axis_frame_valid && m_axis_frame_ready;

  assign load = ((state == ST_FILL) && accept && at_last && can_load) || hold_drain;

  // On the completing beat the last slot is not yet in fill, so splice it in.
  assign load_data = (state == ST_HOLD) ? fill
                                        : {s_axis_pixel_data, fill[FW-W_I-1:0]};

`ifdef AXIS_PIXEL_TO_FRAME_LAST_CHECK_EN
  logic skip_pend;
  logic err_short_q;
  logic err_long_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
    end else begin
      err_short_q <= accept && (state == ST_FILL) && s_axis_pixel_last && !at_last;
      err_long_q  <= accept && (state == ST_FILL) && at_last && !s_axis_pixel_last;
    end
  end

  assign frame_err_short = err_short_q;
  assign frame_err_long  = err_long_q;
`else
  logic unused_last;
  assign unused_last     = s_axis_pixel_last;
  assign frame_err_short = 1'b0;
  assign frame_err_long  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FILL;
      k     <= '0;
      fill  <= '0;
`ifdef AXIS_PIXEL_TO_FRAME_LAST_CHECK_EN
      skip_pend <= 1'b0;
`endif
    end else begin
      case (state)
        ST_FILL: begin
          if (accept) begin
            fill[k*W_I +: W_I] <= s_axis_pixel_data;
            if (at_last) begin
              k <= '0;
              if (!can_load) begin
                state <= ST_HOLD;
              end
`ifdef AXIS_PIXEL_TO_FRAME_LAST_CHECK_EN
              // An over-long frame is still emitted; its tail is discarded afterwards.
              if (!s_axis_pixel_last) begin
                if (can_load) begin
                  state <= ST_SKIP;
                end else begin
                  skip_pend <= 1'b1;
                end
              end
`endif
            end
`ifdef AXIS_PIXEL_TO_FRAME_LAST_CHECK_EN
            else if (s_axis_pixel_last) begin
              k <= '0;
            end
`endif
            else begin
              k <= k + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (hold_drain) begin
            k <= '0;
`ifdef AXIS_PIXEL_TO_FRAME_LAST_CHECK_EN
            state     <= skip_pend ? ST_SKIP : ST_FILL;
            skip_pend <= 1'b0;
`else
            state <= ST_FILL;
`endif
          end
        end
`ifdef AXIS_PIXEL_TO_FRAME_LAST_CHECK_EN
        ST_SKIP: begin
          if (accept && s_axis_pixel_last) begin
            state <= ST_FILL;
          end
        end
`endif
        default: begin
          state <= ST_FILL;
          k     <= '0;
        end
      endcase
    end
  end

  axis_frame_hold_reg #(
    .DW (FW)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .m_ready   (m_axis_frame_ready),
    .m_valid   (m_axis_frame_valid),
    .m_data    (m_axis_frame_data),
    .can_load  (can_load)
  );

endmodule

// File: tb/tb_axis_pixel_to_frame.sv
// tb/tb_axis_pixel_to_frame.sv - directed self-checking bench for axis_pixel_to_frame
module tb_axis_pixel_to_frame;

  localparam int R  = 5;
  localparam int C  = 5;
  localparam int W  = 8;
  localparam int N  = R * C;
  localparam int FW = N * W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_ready;
  logic          s_valid = 1'b0;
  logic [W-1:0]  s_data = '0;
  logic          s_last = 1'b0;
  logic          m_ready = 1'b0;
  logic          m_valid;
  logic [FW-1:0] m_data;
  logic          err_short;
  logic          err_long;

  int n_checks = 0;
  int n_pass   = 0;
  int stall_cnt = 0;
  bit rnd_mode = 1'b0;
  logic [FW-1:0] exp_q[$];

  always #5 clk = ~clk;

  axis_pixel_to_frame #(.R_I(R), .C_I(C), .W_I(W)) dut (
    .clk                (clk),
    .rst                (rst),
    .s_axis_pixel_ready (s_ready),
    .s_axis_pixel_valid (s_valid),
    .s_axis_pixel_data  (s_data),
    .s_axis_pixel_last  (s_last),
    .m_axis_frame_ready (m_ready),
    .m_axis_frame_valid (m_valid),
    .m_axis_frame_data  (m_data),
    .frame_err_short    (err_short),
    .frame_err_long     (err_long)
  );

  task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_mode) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_pixel(input logic [W-1:0] d, input logic l);
    int waited = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready && waited < 2000) begin
      tick();
      waited++;
      stall_cnt++;
    end
    if (!s_ready) begin
      check("beat_timeout", FW'(0), FW'(1));
    end else begin
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] base, input int count, input int last_at,
                            input bit push);
    logic [FW-1:0] f = '0;
    for (int i = 0; i < count; i++) begin
      logic [W-1:0] px = base + W'(i);
      if (i < N) f[i*W +: W] = px;
      send_pixel(px, (i + 1) == last_at);
    end
    if (push) exp_q.push_back(f);
  endtask

  // Output monitor: a presented frame must equal the scoreboard head until taken.
  always @(negedge clk) begin
    if (!rst && m_valid) begin
      if (exp_q.size() == 0) check("extra_frame", FW'(1), FW'(0));
      else begin
        check("frame_data", m_data, exp_q[0]);
        if (m_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [FW-1:0] fa;
    // Reset state.
    #1 rst = 1'b1;
    #1;
    check("rst_s_ready", FW'(s_ready), FW'(0));
    check("rst_m_valid", FW'(m_valid), FW'(0));
    check("rst_m_data",  m_data,       FW'(0));
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_s_ready", FW'(s_ready), FW'(1));

    // Single frame 0x01..0x19 with latency check around the last pixel.
    m_ready = 1'b1;
    fa = '0;
    for (int i = 0; i < N; i++) begin
      fa[i*W +: W] = W'(i + 1);
      send_pixel(W'(i + 1), i == N - 1);
      if (i == N - 2) check("valid_before_last", FW'(m_valid), FW'(0));
    end
    exp_q.push_back(fa);
    check("valid_after_last", FW'(m_valid), FW'(1));
    check("first_pixel_lsb", FW'(m_data[7:0]), FW'(8'h01));
    check("last_pixel_msb",  FW'(m_data[199:192]), FW'(8'h19));
    tick();

    // Back-to-back frames with no stalls.
    stall_cnt = 0;
    send_frame(8'h30, N, N, 1'b1);
    send_frame(8'h50, N, N, 1'b1);
    check("no_bubbles", FW'(stall_cnt), FW'(0));
    tick();
    tick();

    // Backpressure: two frames pile up, then drain in order.
    m_ready = 1'b0;
    send_frame(8'h60, N, N, 1'b1);
    fa = exp_q[exp_q.size() - 1];
    send_frame(8'h80, N, N, 1'b1);
    check("hold_s_ready", FW'(s_ready), FW'(0));
    check("hold_m_data_a", m_data, fa);
    tick();
    check("hold_still_blocked", FW'(s_ready), FW'(0));
    m_ready = 1'b1;
    tick();
    check("reload_valid", FW'(m_valid), FW'(1));
    check("reload_s_ready", FW'(s_ready), FW'(1));
    tick();
    check("drained_valid", FW'(m_valid), FW'(0));
    check("drain_queue", FW'(exp_q.size()), FW'(0));

`ifndef AXIS_PIXEL_TO_FRAME_LAST_CHECK_EN
    // Without the check, last is ignored: framing follows the count.
    send_frame(8'hC0, N, 10, 1'b1);
    check("ignore_last_valid", FW'(m_valid), FW'(1));
    tick();
`else
    // Short frame: dropped with a one-cycle error pulse.
    send_frame(8'hC0, 10, 10, 1'b0);
    check("short_pulse", FW'(err_short), FW'(1));
    tick();
    check("short_pulse_end", FW'(err_short), FW'(0));
    check("short_no_frame", FW'(m_valid), FW'(0));
    send_frame(8'hD0, N, N, 1'b1);
    tick();
    // Long frame: first N pixels emitted, tail skipped until last.
    fa = '0;
    for (int i = 0; i < N; i++) begin
      fa[i*W +: W] = 8'h10 + W'(i);
      send_pixel(8'h10 + W'(i), 1'b0);
    end
    exp_q.push_back(fa);
    check("long_pulse", FW'(err_long), FW'(1));
    send_pixel(8'hEE, 1'b0);
    check("long_pulse_end", FW'(err_long), FW'(0));
    send_pixel(8'hEF, 1'b1);
    send_frame(8'h40, N, N, 1'b1);
    tick();
`endif

    // Randomly stalled downstream, 100 frames.
    rnd_mode = 1'b1;
    for (int f = 0; f < 100; f++) send_frame(W'(f * 3), N, N, 1'b1);
    rnd_mode = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) tick();
    check("random_drained", FW'(exp_q.size()), FW'(0));

    // Reset mid-frame discards the held and the partial frame.
    m_ready = 1'b0;
    send_frame(8'h70, N, N, 1'b1);
    send_frame(8'h90, 12, 0, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_m_valid", FW'(m_valid), FW'(0));
    check("midrst_m_data",  m_data,       FW'(0));
    check("midrst_s_ready", FW'(s_ready), FW'(0));
    void'(exp_q.pop_front());
    tick();
    rst = 1'b0;
    #1;
    check("midrst_release_ready", FW'(s_ready), FW'(1));
    m_ready = 1'b1;
    send_frame(8'hA0, N, N, 1'b1);
    check("after_rst_valid", FW'(m_valid), FW'(1));
    check("after_rst_lsb", FW'(m_data[7:0]), FW'(8'hA0));
    tick();
    tick();
    check("final_queue", FW'(exp_q.size()), FW'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
